// File: rtl/ram_stream_pkg.sv
// Shared constants and types for ram_stream_ctrl and the data RAM it drives.
// The default widths here are also used to size the RAM instance.
package ram_stream_pkg;

   localparam int unsigned RAM_AWIDTH = 3;
   localparam int unsigned RAM_DWIDTH = 32;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRead  = 2'd1,
      StDrain = 2'd2
   } state_e;

   function automatic int unsigned depth_of(input int unsigned awidth);
      return 32'd1 << awidth;
   endfunction

endpackage

// File: rtl/ram_stream_skid.sv
// Two-entry registered output buffer for the read stream. The space output
// tells the parent whether another RAM read may be launched this cycle.
module ram_stream_skid #(
   parameter int unsigned DWIDTH = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              push,
   input  logic [DWIDTH-1:0] push_data,
   input  logic              push_last,
   output logic              space,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DWIDTH-1:0] out_data,
   output logic              out_last
);

   logic [1:0]        count_q, count_d;
   logic [DWIDTH-1:0] head_data_q, head_data_d;
   logic [DWIDTH-1:0] tail_data_q, tail_data_d;
   logic              head_last_q, head_last_d;
   logic              tail_last_q, tail_last_d;
   logic              pop;
   logic [1:0]        level;

   assign out_valid = (count_q != 2'd0);
   assign out_data  = head_data_q;
   assign out_last  = out_valid & head_last_q;
   assign pop       = out_valid & out_ready;

   // Occupancy after this edge, counting the word landing now; a read issued
   // this cycle lands one edge later and needs a free slot then.
   assign level = count_q + {1'b0, push} - {1'b0, pop};
   assign space = (level < 2'd2);

   always_comb begin
      count_d     = count_q;
      head_data_d = head_data_q;
      head_last_d = head_last_q;
      tail_data_d = tail_data_q;
      tail_last_d = tail_last_q;
      if (pop) begin
         if (count_q == 2'd2) begin
            head_data_d = tail_data_q;
            head_last_d = tail_last_q;
            if (push) begin
               tail_data_d = push_data;
               tail_last_d = push_last;
            end else begin
               count_d = 2'd1;
            end
         end else begin
            if (push) begin
               head_data_d = push_data;
               head_last_d = push_last;
            end else begin
               count_d = 2'd0;
            end
         end
      end else if (push) begin
         if (count_q == 2'd0) begin
            head_data_d = push_data;
            head_last_d = push_last;
            count_d     = 2'd1;
         end else begin
            tail_data_d = push_data;
            tail_last_d = push_last;
            count_d     = 2'd2;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q     <= 2'd0;
         head_data_q <= '0;
         head_last_q <= 1'b0;
         tail_data_q <= '0;
         tail_last_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         head_data_q <= head_data_d;
         head_last_q <= head_last_d;
         tail_data_q <= tail_data_d;
         tail_last_q <= tail_last_d;
      end
   end

endmodule

// File: rtl/ram_stream_ctrl.sv
// Write-stream / read-burst controller owning a single-port sync-read RAM.
// Define RAM_STREAM_WRAP_EN to let the write pointer wrap instead of filling up.
module ram_stream_ctrl
   import ram_stream_pkg::*;
#(
   parameter int unsigned AWIDTH = RAM_AWIDTH,
   parameter int unsigned DWIDTH = RAM_DWIDTH
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DWIDTH-1:0] in_data,
   input  logic              rd_start,
   input  logic [AWIDTH-1:0] rd_base,
   input  logic [AWIDTH:0]   rd_len,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DWIDTH-1:0] out_data,
   output logic              out_last,
   output logic [AWIDTH-1:0] ram_addr,
   output logic [DWIDTH-1:0] ram_din,
   output logic              ram_we,
   input  logic [DWIDTH-1:0] ram_dout,
   output logic              busy,
   output logic              full,
   output logic [AWIDTH:0]   wr_count
);

   localparam int unsigned     DEPTH   = depth_of(AWIDTH);
   localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH + 1)'(DEPTH);

   state_e            state_q, state_d;
   logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [AWIDTH:0]   wr_count_q, wr_count_d;
   logic [AWIDTH-1:0] rd_base_q, rd_base_d;
   logic [AWIDTH:0]   rd_len_q, rd_len_d;
   logic [AWIDTH:0]   issued_q, issued_d;
   logic              inflight_q, inflight_d;
   logic              inflight_last_q, inflight_last_d;

   logic idle;
   logic accept;
   logic issue;
   logic last_issue;
   logic space;
   logic full_int;

`ifdef RAM_STREAM_WRAP_EN
   assign full_int = 1'b0;
`else
   assign full_int = (wr_count_q == DEPTH_W);
`endif

   assign idle       = (state_q == StIdle);
   assign in_ready   = reset_n & idle & ~rd_start & ~clear & ~full_int;
   assign accept     = in_valid & in_ready;
   assign issue      = (state_q == StRead) & space;
   assign last_issue = issue & ((issued_q + 1'b1) == rd_len_q);

   assign busy     = ~idle;
   assign full     = full_int;
   assign wr_count = wr_count_q;

   // Read FSM and burst bookkeeping.
   always_comb begin
      state_d         = state_q;
      rd_base_d       = rd_base_q;
      rd_len_d        = rd_len_q;
      issued_d        = issued_q;
      inflight_d      = issue;
      inflight_last_d = last_issue;
      unique case (state_q)
         StIdle: begin
            if (rd_start && (rd_len != '0)) begin
               rd_base_d = rd_base;
               rd_len_d  = (rd_len > DEPTH_W) ? DEPTH_W : rd_len;
               issued_d  = '0;
               state_d   = StRead;
            end
         end
         StRead: begin
            if (issue) begin
               issued_d = issued_q + 1'b1;
               if (last_issue) begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            if (out_valid && out_ready && out_last) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Write side; clear only touches this half and never aborts a burst.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      wr_count_d = wr_count_q;
      if (clear) begin
         wr_ptr_d   = '0;
         wr_count_d = '0;
      end else if (accept) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
`ifdef RAM_STREAM_WRAP_EN
         if (wr_count_q != DEPTH_W) begin
            wr_count_d = wr_count_q + 1'b1;
         end
`else
         wr_count_d = wr_count_q + 1'b1;
`endif
      end
   end

   always_comb begin
      ram_we   = accept;
      ram_din  = reset_n ? in_data : '0;
      ram_addr = (state_q == StRead) ? (rd_base_q + issued_q[AWIDTH-1:0]) : wr_ptr_q;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= StIdle;
         wr_ptr_q        <= '0;
         wr_count_q      <= '0;
         rd_base_q       <= '0;
         rd_len_q        <= '0;
         issued_q        <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         wr_ptr_q        <= wr_ptr_d;
         wr_count_q      <= wr_count_d;
         rd_base_q       <= rd_base_d;
         rd_len_q        <= rd_len_d;
         issued_q        <= issued_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
      end
   end

   // ram_dout belongs to the address issued on the previous cycle.
   ram_stream_skid #(
      .DWIDTH(DWIDTH)
   ) u_skid (
      .clock    (clock),
      .reset_n  (reset_n),
      .push     (inflight_q),
      .push_data(ram_dout),
      .push_last(inflight_last_q),
      .space    (space),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_last (out_last)
   );

endmodule

// File: tb/tb_ram_stream_ctrl.sv
// Self-checking bench for ram_stream_ctrl with a behavioural RAM and an
// array/counter reference model of the write pointer and RAM contents.
`timescale 1ns/1ps
module tb_ram_stream_ctrl;
   import ram_stream_pkg::*;

   localparam int unsigned AW    = RAM_AWIDTH;
   localparam int unsigned DW    = RAM_DWIDTH;
   localparam int unsigned DEPTH = 1 << AW;
`ifdef RAM_STREAM_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset_n;
   logic          clear;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          rd_start;
   logic [AW-1:0] rd_base;
   logic [AW:0]   rd_len;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic          ram_we;
   logic [DW-1:0] ram_dout;
   logic          busy;
   logic          full;
   logic [AW:0]   wr_count;

   int total;
   int bad;

   logic [DW-1:0] ram_mem   [DEPTH];
   logic [DW-1:0] model_mem [DEPTH];
   int            m_ptr;
   int            m_cnt;

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (ram_we) ram_mem[ram_addr] <= ram_din;
      ram_dout <= ram_mem[ram_addr];
   end

   ram_stream_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .clear    (clear),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .rd_start (rd_start),
      .rd_base  (rd_base),
      .rd_len   (rd_len),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_last (out_last),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_we   (ram_we),
      .ram_dout (ram_dout),
      .busy     (busy),
      .full     (full),
      .wr_count (wr_count)
   );

   function automatic bit m_full();
      return !WRAP && (m_cnt == int'(DEPTH));
   endfunction

   task automatic model_write(input logic [DW-1:0] d);
      model_mem[m_ptr] = d;
      m_ptr = (m_ptr + 1) % DEPTH;
      if (m_cnt < int'(DEPTH)) m_cnt++;
   endtask

   task automatic drive_write(input logic [DW-1:0] d);
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = d;
      if (!m_full()) model_write(d);
   endtask

   task automatic do_clear();
      @(negedge clock);
      in_valid = 1'b0;
      clear    = 1'b1;
      m_ptr    = 0;
      m_cnt    = 0;
      @(negedge clock);
      clear = 1'b0;
   endtask

   task automatic preload();
      do_clear();
      for (int k = 0; k < int'(DEPTH); k++) drive_write(DW'(32'h10 + k));
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   // mode 0: always ready, 1: fixed stall pattern, 2: random ready.
   task automatic do_read(input logic [AW-1:0] base, input logic [AW:0] len, input int mode,
                          input bit chk_timing, input bit noise);
      int            exp_n, got, cyc, pidx, first_acc, last_acc, idx;
      bit            stalled;
      logic [DW-1:0] held;
      logic [6:0]    pat;
      pat   = 7'b1101001;
      exp_n = (int'(len) > int'(DEPTH)) ? int'(DEPTH) : int'(len);
      @(negedge clock);
      in_valid = 1'b0; rd_start = 1'b1; rd_base = base; rd_len = len; out_ready = 1'b0;
      #1;
      total++;
      if (in_ready !== 1'b0) begin
         bad++; $display("FAIL rd_start_blocks_write: in_ready=%b want 0", in_ready);
      end
      @(negedge clock);
      rd_start = 1'b0;
      #1;
      total++;
      if (busy !== (exp_n != 0)) begin
         bad++; $display("FAIL busy_after_start: busy=%b want %b len=%0d", busy, exp_n != 0, len);
      end
      got = 0; cyc = 0; pidx = 0; stalled = 0; held = '0; first_acc = -1; last_acc = -1;
      while (got < exp_n && cyc < 200) begin
         if (mode == 0) out_ready = 1'b1;
         else if (mode == 1) out_ready = (pidx < 7) ? pat[pidx] : 1'b1;
         else out_ready = ($urandom_range(0, 3) != 0);
         if (noise) begin
            in_valid = $urandom_range(0, 1) == 1;
            in_data  = $urandom;
            rd_start = $urandom_range(0, 1) == 1;
            rd_base  = AW'($urandom);
            rd_len   = (AW + 1)'($urandom);
            clear    = $urandom_range(0, 7) == 0;
            if (clear) begin m_ptr = 0; m_cnt = 0; end
         end
         #1;
         total++;
         if ({busy, ram_we, in_ready} !== 3'b100) begin
            bad++; $display("FAIL read_busy_nowrite: busy/we/rdy=%b want 100", {busy, ram_we, in_ready});
         end
         if (chk_timing && cyc < 3) begin
            total++;
            if (out_valid !== (cyc == 2)) begin
               bad++; $display("FAIL first_word_latency: cyc=%0d out_valid=%b want %b",
                               cyc, out_valid, cyc == 2);
            end
         end
         if (stalled) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== held) begin
               bad++; $display("FAIL stall_stable: valid=%b data=%h want 1 %h", out_valid, out_data, held);
            end
         end
         if (out_valid === 1'b1 && out_ready) begin
            idx = (int'(base) + got) % DEPTH;
            total++;
            if (out_data !== model_mem[idx] || out_last !== (got == exp_n - 1)) begin
               bad++; $display("FAIL read_word[%0d]: data=%h last=%b want %h %b",
                               got, out_data, out_last, model_mem[idx], got == exp_n - 1);
            end
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
            got++;
            stalled = 0;
         end else begin
            stalled = (out_valid === 1'b1);
            held    = out_data;
         end
         if (out_valid === 1'b1 || pidx > 0) pidx++;
         @(negedge clock);
         cyc++;
      end
      in_valid = 1'b0; rd_start = 1'b0; clear = 1'b0;
      #1;
      total++;
      if (got != exp_n) begin
         bad++; $display("FAIL read_count: got %0d words want %0d", got, exp_n);
      end
      total++;
      if ({busy, out_valid} !== 2'b00) begin
         bad++; $display("FAIL busy_drop: busy/valid=%b want 00", {busy, out_valid});
      end
      total++;
      if (wr_count !== (AW + 1)'(m_cnt)) begin
         bad++; $display("FAIL wr_count_after_read: %0d want %0d", wr_count, m_cnt);
      end
      if (chk_timing && exp_n > 0) begin
         total++;
         if (last_acc - first_acc != exp_n - 1) begin
            bad++; $display("FAIL no_bubbles: span=%0d want %0d", last_acc - first_acc, exp_n - 1);
         end
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF;
      repeat (2) @(negedge clock);
      #1;
      total++;
      if ({out_valid, out_last, busy, full, ram_we, in_ready} !== 6'b0) begin
         bad++; $display("FAIL reset_flags: %b want 000000",
                         {out_valid, out_last, busy, full, ram_we, in_ready});
      end
      total++;
      if (out_data !== '0 || ram_din !== '0) begin
         bad++; $display("FAIL reset_data: out_data=%h ram_din=%h want 0 0", out_data, ram_din);
      end
      total++;
      if (ram_addr !== '0 || wr_count !== '0) begin
         bad++; $display("FAIL reset_addr_count: addr=%0d cnt=%0d want 0 0", ram_addr, wr_count);
      end
      in_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      m_ptr = 0; m_cnt = 0;
   endtask

   task automatic test_write_basic();
      logic [DW-1:0] d;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         d = DW'(32'hA0) + DW'(k);
         in_valid = 1'b1; in_data = d;
         #1;
         total++;
         if ({ram_we, in_ready, ram_addr, ram_din} !== {1'b1, 1'b1, AW'(k), d}) begin
            bad++; $display("FAIL write_basic[%0d]: we=%b rdy=%b addr=%0d din=%h want 1 1 %0d %h",
                            k, ram_we, in_ready, ram_addr, ram_din, k, d);
         end
         model_write(d);
      end
      @(negedge clock);
      in_valid = 1'b0;
      #1;
      total++;
      if (wr_count !== 4'd3 || busy !== 1'b0) begin
         bad++; $display("FAIL write_basic_count: cnt=%0d busy=%b want 3 0", wr_count, busy);
      end
   endtask

   task automatic test_fill();
      bit            exp_rdy;
      logic [DW-1:0] d;
      do_clear();
      for (int k = 0; k < int'(DEPTH) + 1; k++) begin
         @(negedge clock);
         d = DW'(32'hB0) + DW'(k);
         in_valid = 1'b1; in_data = d;
         #1;
         exp_rdy = !m_full();
         total++;
         if ({in_ready, ram_we, full} !== {exp_rdy, exp_rdy, !exp_rdy}) begin
            bad++; $display("FAIL fill_step[%0d]: rdy/we/full=%b want %b", k,
                            {in_ready, ram_we, full}, {exp_rdy, exp_rdy, !exp_rdy});
         end
         if (exp_rdy) begin
            total++;
            if (ram_addr !== AW'(m_ptr)) begin
               bad++; $display("FAIL fill_addr[%0d]: addr=%0d want %0d", k, ram_addr, m_ptr);
            end
            model_write(d);
         end
      end
      @(negedge clock);
      in_valid = 1'b0;
      #1;
      total++;
      if (full !== m_full() || wr_count !== (AW + 1)'(m_cnt)) begin
         bad++; $display("FAIL fill_end: full=%b cnt=%0d want %b %0d", full, wr_count, m_full(), m_cnt);
      end
      do_read(AW'(0), (AW + 1)'(DEPTH), 0, 0, 0);
      do_clear();
      #1;
      total++;
      if (full !== 1'b0 || wr_count !== '0) begin
         bad++; $display("FAIL clear: full=%b cnt=%0d want 0 0", full, wr_count);
      end
   endtask

   task automatic test_start_vs_write();
      int cyc, got;
      do_clear();
      drive_write(32'h20);
      drive_write(32'h21);
      @(negedge clock);
      in_valid = 1'b1; in_data = 32'h55; rd_start = 1'b1; rd_base = '0; rd_len = 2; out_ready = 1'b1;
      #1;
      total++;
      if ({ram_we, in_ready} !== 2'b00) begin
         bad++; $display("FAIL start_beats_write: we/rdy=%b want 00", {ram_we, in_ready});
      end
      @(negedge clock);
      rd_start = 1'b0;
      cyc = 0; got = 0;
      while (busy === 1'b1 && cyc < 50) begin
         #1;
         total++;
         if (ram_we !== 1'b0) begin
            bad++; $display("FAIL held_write_stalled: we=%b want 0", ram_we);
         end
         if (out_valid === 1'b1) begin
            total++;
            if (out_data !== model_mem[got % DEPTH]) begin
               bad++; $display("FAIL held_read[%0d]: data=%h want %h", got, out_data, model_mem[got % DEPTH]);
            end
            got++;
         end
         @(negedge clock);
         cyc++;
      end
      #1;
      total++;
      if ({busy, ram_we, ram_addr, got[3:0]} !== {1'b0, 1'b1, AW'(m_ptr), 4'd2}) begin
         bad++; $display("FAIL held_write_after_busy: busy=%b we=%b addr=%0d words=%0d want 0 1 %0d 2",
                         busy, ram_we, ram_addr, got, m_ptr);
      end
      model_write(32'h55);
      @(negedge clock);
      in_valid = 1'b0;
      #1;
      total++;
      if (wr_count !== (AW + 1)'(m_cnt)) begin
         bad++; $display("FAIL held_write_count: cnt=%0d want %0d", wr_count, m_cnt);
      end
      do_read(AW'(0), 4'd3, 0, 0, 0);
   endtask

   task automatic test_random_bursts();
      for (int it = 0; it < 16; it++) begin
         if ($urandom_range(0, 2) == 0) do_clear();
         for (int w = 0; w < int'($urandom_range(0, 3)); w++) drive_write($urandom);
         @(negedge clock);
         in_valid = 1'b0;
         do_read(AW'($urandom), (AW + 1)'($urandom_range(0, 15)), 2, 0, 1);
      end
   endtask

   task automatic test_reset_mid_burst();
      int  got, cyc;
      bit  done;
      preload();
      @(negedge clock);
      rd_start = 1'b1; rd_base = '0; rd_len = 8; out_ready = 1'b1;
      @(negedge clock);
      rd_start = 1'b0;
      got = 0; cyc = 0; done = 0;
      while (!done && cyc < 50) begin
         if (out_valid === 1'b1 && got == 1) begin
            #2 reset_n = 1'b0;
            #1;
            total++;
            if ({out_valid, busy, out_last} !== 3'b000) begin
               bad++; $display("FAIL async_flush: valid/busy/last=%b want 000", {out_valid, busy, out_last});
            end
            done = 1;
         end else begin
            if (out_valid === 1'b1) got++;
            @(negedge clock);
            cyc++;
         end
      end
      total++;
      if (!done) begin
         bad++; $display("FAIL mid_burst_timeout: words=%0d want 2nd word reached", got);
      end
      out_ready = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      m_ptr = 0; m_cnt = 0;
      do_read(AW'(0), 4'd8, 0, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      total = 0; bad = 0;
      reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
      rd_start = 1'b0; rd_base = '0; rd_len = '0; out_ready = 1'b0;
      m_ptr = 0; m_cnt = 0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         ram_mem[i]   = '0;
         model_mem[i] = '0;
      end
      test_reset();
      test_write_basic();
      test_fill();
      preload();
      do_read(AW'(6), 4'd4, 0, 1, 0);
      do_read(AW'(6), 4'd4, 1, 0, 0);
      do_read(AW'(3), 4'd15, 0, 1, 0);
      do_read(AW'(2), 4'd0, 0, 0, 0);
      test_start_vs_write();
      test_random_bursts();
      test_reset_mid_burst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_stream_ctrl.md
# ram_stream_ctrl

Stream controller sitting directly upstream of the single-port synchronous-read data RAM, and owning all of that RAM's ports. It accepts a valid/ready write stream and writes words to sequential RAM addresses. On command it bursts a range of the RAM back out as a valid/ready read stream, absorbing the RAM's one-cycle read latency and downstream backpressure. Reads and writes are mutually exclusive because the RAM has a single address port.

## Interface
- AWIDTH, 3: RAM address width; DEPTH = 1 << AWIDTH.
- DWIDTH, 32: data word width.
- clock  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous: zero write pointer, wr_count and full.
- in_valid / in_ready / in_data  in / out / DWIDTH  write stream.
- rd_start  in  1  pulse: begin read burst (sampled in IDLE only).
- rd_base  in  AWIDTH  first read address.
- rd_len  in  AWIDTH+1  words to read.
- out_valid / out_ready / out_data / out_last  out / in / DWIDTH / 1  read stream; out_last marks the final word.
- ram_addr  out  AWIDTH  to RAM addr.
- ram_din  out  DWIDTH  to RAM din.
- ram_we  out  1  to RAM we.
- ram_dout  in  DWIDTH  from RAM dout; valid the cycle after the address is clocked.
- busy  out  1  state != IDLE.
- full  out  1  write side full.
- wr_count  out  AWIDTH+1  words written since reset/clear.

## Operation
- States:
  - IDLE: writes allowed.
  - READ: issuing read addresses.
  - DRAIN: all addresses issued, output buffer not yet empty.
- in_ready = reset_n & IDLE & !rd_start & !clear & !full.
- IDLE, write path:
  - ram_addr = wr_ptr; ram_din = in_data; ram_we = in_valid & in_ready.
  - Each accepted word increments wr_ptr and wr_count.
- rd_start in IDLE:
  - rd_len = 0: no-op, stay in IDLE.
  - rd_len > DEPTH: clamp to DEPTH.
  - Otherwise latch base/len and go to READ.
  - rd_start outside IDLE is ignored.
- READ:
  - ram_we = 0; ram_addr = (rd_base + issued) mod DEPTH (wraps 7 -> 0 for AWIDTH=3).
  - Issue an address only when buffer occupancy + in-flight < 2.
  - After the last issue go to DRAIN.
- DRAIN: return to IDLE in the cycle after the word with out_last is accepted (out_valid & out_ready).
- Output buffer is 2 entries:
  - out_data is registered and held stable while out_valid & !out_ready.
  - No word is dropped or duplicated.
- clear in any state resets the write side only; it does not abort a read.
- Reset values: out_valid, out_last, out_data, ram_we, ram_addr, ram_din, busy, full and wr_count are all 0; state is IDLE. RAM contents are untouched.
- Reset mid-burst: the burst is abandoned and buffers are flushed immediately (asynchronously).

## Timing
- Write: zero added latency; the word is written on the same edge that accepts it; one word per cycle sustained.
- Read, first word:
  - rd_start is sampled at edge E0.
  - Address issued in the cycle after E0 and clocked into the RAM at E1.
  - ram_dout is captured at E2; out_valid rises after E2.
- Read, sustained: with out_ready held high, one word per cycle and no bubbles.
- busy rises the cycle after rd_start is accepted and falls the cycle after out_last is accepted.
- rd_start and in_valid in the same cycle: the read wins; the write is stalled (in_ready = 0).

## Configuration
- RAM_STREAM_WRAP_EN defined:
  - wr_ptr wraps DEPTH-1 -> 0 and continues, overwriting the oldest data.
  - wr_count saturates at DEPTH; full is tied to 0.
- Undefined:
  - full asserts when wr_count = DEPTH; in_ready then drops.
  - No further writes until clear.

## Structure
- Shared package ram_stream_pkg:
  - State encoding (IDLE=0, READ=1, DRAIN=2).
  - DEPTH derivation.
  - Default AWIDTH/DWIDTH constants, shared with the RAM instance.
- Sub-module ram_stream_skid: 2-entry output buffer exposing a space-available signal. Parent keeps the FSM, pointers and in-flight tracking.

## Test plan
- Reset, then write 0xA0, 0xA1, 0xA2 back-to-back -> ram_we high 3 cycles at ram_addr 0, 1, 2; wr_count = 3; busy = 0.
- Write 9 words with macro off -> full = 1 after the 8th, in_ready = 0, 9th not written. With RAM_STREAM_WRAP_EN -> 9th written at addr 0, wr_count = 8, full = 0.
- Preload addr k = 0x10+k; rd_base = 6, rd_len = 4, out_ready = 1 -> out_data 0x16, 0x17, 0x10, 0x11 on consecutive cycles; first out_valid 2 cycles after rd_start; out_last only on 0x11.
- Same read with out_ready pattern 1,0,0,1,0,1,1 -> exactly 4 words in order; out_data stable during stalls; busy drops the cycle after the last accept.
- rd_start and in_valid asserted together in IDLE -> no ram_we that cycle. in_valid held -> its word is written the cycle after busy falls, at the unchanged wr_ptr.
- reset_n low during the 2nd word of an 8-word read -> out_valid and busy go 0 immediately. After release, a new read of the same range returns unchanged RAM data.
